// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - WISC pipeline control: ID decode plus ID/EX, EX/MEM, MEM/WB control registers
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_valid, id_opcode   instruction presence and opcode from IF/ID
//   id_rd                 destination register field from IF/ID
//   stall                 load-use stall, injects a bubble into ID/EX
//   flush                 taken branch, kills the instruction in ID
//   mem_busy              data memory not ready, freezes all three stage registers
//   id_reg_src1           combinational: read port 1 uses rd (LLB/LHB)
//   id_stall_fetch        combinational: PC and IF/ID must hold
//   ex_*                  ID/EX control bits and ALU operation
//   mem_*                 EX/MEM control bits and destination tag
//   wb_*                  MEM/WB control bits and destination tag
//   halted                sticky halt indication
module pipelined_control_unit #(
   parameter int REG_ADDR_W = 4,
   parameter bit HALT_DRAIN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [3:0]            id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  mem_busy,
   output logic                  id_reg_src1,
   output logic                  id_stall_fetch,
   output logic                  ex_valid,
   output logic                  ex_alu_src,
   output logic                  ex_branch,
   output logic                  ex_pcs,
   output logic [3:0]            ex_alu_op,
   output logic                  mem_valid,
   output logic                  mem_enable,
   output logic                  mem_write,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  wb_valid,
   output logic                  wb_mem_to_reg,
   output logic                  wb_reg_write,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  halted
);

   // ID decode
   logic d_alu_src, d_mem_to_reg, d_reg_write, d_mem_enable;
   logic d_mem_write, d_branch, d_pcs, d_hlt;

   always_comb begin
      d_alu_src    = (id_opcode >= 4'b0100) && (id_opcode <= 4'b1011);
      d_mem_to_reg = (id_opcode == 4'b1000);
      d_reg_write  = (id_opcode <= 4'b1000) || (id_opcode == 4'b1010) ||
                     (id_opcode == 4'b1011) || (id_opcode == 4'b1110);
      d_mem_enable = (id_opcode == 4'b1000) || (id_opcode == 4'b1001);
      d_mem_write  = (id_opcode == 4'b1001);
      d_branch     = (id_opcode == 4'b1100) || (id_opcode == 4'b1101);
      d_pcs        = (id_opcode == 4'b1110);
      d_hlt        = (id_opcode == 4'b1111);
   end

   assign id_reg_src1 = (id_opcode == 4'b1010) || (id_opcode == 4'b1011);

   logic hlt_seen;
   logic id_ok, id_take;

   // Once an HLT has been accepted, nothing further leaves ID.
   assign id_ok          = id_valid & ~flush & ~hlt_seen;
   assign id_take        = id_ok & ~stall;
   assign id_stall_fetch = stall | mem_busy | hlt_seen;

   // Stage fields that are not module outputs
   logic                  ex_mem_enable, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_hlt;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  mem_mem_to_reg, mem_reg_write, mem_hlt;

   // Drain mode waits for the HLT to reach MEM/WB so older instructions retire first.
   logic halt_set;
   assign halt_set = HALT_DRAIN ? (mem_valid & mem_hlt) : (id_take & d_hlt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid       <= 1'b0;
         ex_alu_src     <= 1'b0;
         ex_branch      <= 1'b0;
         ex_pcs         <= 1'b0;
         ex_alu_op      <= 4'b0000;
         ex_mem_enable  <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_mem_to_reg  <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_hlt         <= 1'b0;
         ex_rd          <= '0;
         mem_valid      <= 1'b0;
         mem_enable     <= 1'b0;
         mem_write      <= 1'b0;
         mem_mem_to_reg <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_hlt        <= 1'b0;
         mem_rd         <= '0;
         wb_valid       <= 1'b0;
         wb_mem_to_reg  <= 1'b0;
         wb_reg_write   <= 1'b0;
         wb_rd          <= '0;
         hlt_seen       <= 1'b0;
         halted         <= 1'b0;
      end else if (!mem_busy) begin
         if (id_take) begin
            ex_valid      <= 1'b1;
            ex_alu_src    <= d_alu_src;
            ex_branch     <= d_branch;
            ex_pcs        <= d_pcs;
            ex_alu_op     <= id_opcode;
            ex_mem_enable <= d_mem_enable;
            ex_mem_write  <= d_mem_write;
            ex_mem_to_reg <= d_mem_to_reg;
            ex_reg_write  <= d_reg_write;
            ex_hlt        <= d_hlt;
            ex_rd         <= id_rd;
            if (d_hlt) begin
               hlt_seen <= 1'b1;
            end
         end else begin
            ex_valid      <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_branch     <= 1'b0;
            ex_pcs        <= 1'b0;
            ex_alu_op     <= 4'b0000;
            ex_mem_enable <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_hlt        <= 1'b0;
            ex_rd         <= '0;
         end
         mem_valid      <= ex_valid;
         mem_enable     <= ex_mem_enable;
         mem_write      <= ex_mem_write;
         mem_mem_to_reg <= ex_mem_to_reg;
         mem_reg_write  <= ex_reg_write;
         mem_hlt        <= ex_hlt;
         mem_rd         <= ex_rd;
         wb_valid       <= mem_valid;
         wb_mem_to_reg  <= mem_mem_to_reg;
         wb_reg_write   <= mem_reg_write;
         wb_rd          <= mem_rd;
         if (halt_set) begin
            halted <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - self-checking bench for pipelined_control_unit
module tb_pipelined_control_unit;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          id_valid = 1'b0;
   logic [3:0]    id_opcode = 4'd0;
   logic [RW-1:0] id_rd = '0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          mem_busy = 1'b0;

   logic a_id_reg_src1, a_id_stall_fetch, a_ex_valid, a_ex_alu_src, a_ex_branch, a_ex_pcs;
   logic [3:0] a_ex_alu_op;
   logic a_mem_valid, a_mem_enable, a_mem_write, a_wb_valid, a_wb_mem_to_reg, a_wb_reg_write, a_halted;
   logic [RW-1:0] a_mem_rd, a_wb_rd;

   logic b_id_reg_src1, b_id_stall_fetch, b_ex_valid, b_ex_alu_src, b_ex_branch, b_ex_pcs;
   logic [3:0] b_ex_alu_op;
   logic b_mem_valid, b_mem_enable, b_mem_write, b_wb_valid, b_wb_mem_to_reg, b_wb_reg_write, b_halted;
   logic [RW-1:0] b_mem_rd, b_wb_rd;

   pipelined_control_unit #(.REG_ADDR_W(RW), .HALT_DRAIN(1'b1)) u_drain1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
      .stall(stall), .flush(flush), .mem_busy(mem_busy),
      .id_reg_src1(a_id_reg_src1), .id_stall_fetch(a_id_stall_fetch),
      .ex_valid(a_ex_valid), .ex_alu_src(a_ex_alu_src), .ex_branch(a_ex_branch), .ex_pcs(a_ex_pcs),
      .ex_alu_op(a_ex_alu_op), .mem_valid(a_mem_valid), .mem_enable(a_mem_enable),
      .mem_write(a_mem_write), .mem_rd(a_mem_rd), .wb_valid(a_wb_valid),
      .wb_mem_to_reg(a_wb_mem_to_reg), .wb_reg_write(a_wb_reg_write), .wb_rd(a_wb_rd),
      .halted(a_halted)
   );

   pipelined_control_unit #(.REG_ADDR_W(RW), .HALT_DRAIN(1'b0)) u_drain0 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
      .stall(stall), .flush(flush), .mem_busy(mem_busy),
      .id_reg_src1(b_id_reg_src1), .id_stall_fetch(b_id_stall_fetch),
      .ex_valid(b_ex_valid), .ex_alu_src(b_ex_alu_src), .ex_branch(b_ex_branch), .ex_pcs(b_ex_pcs),
      .ex_alu_op(b_ex_alu_op), .mem_valid(b_mem_valid), .mem_enable(b_mem_enable),
      .mem_write(b_mem_write), .mem_rd(b_mem_rd), .wb_valid(b_wb_valid),
      .wb_mem_to_reg(b_wb_mem_to_reg), .wb_reg_write(b_wb_reg_write), .wb_rd(b_wb_rd),
      .halted(b_halted)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit started = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the instruction (opcode, rd) occupying each stage; index 0=EX, 1=MEM, 2=WB.
   logic          m_v [3];
   logic [3:0]    m_op[3];
   logic [RW-1:0] m_rd[3];
   logic          m_hseen, m_halted;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            m_v[i]  <= 1'b0;
            m_op[i] <= 4'd0;
            m_rd[i] <= '0;
         end
         m_hseen  <= 1'b0;
         m_halted <= 1'b0;
      end else if (!mem_busy) begin
         if (m_v[1] && m_op[1] == 4'd15) m_halted <= 1'b1;
         if (id_valid && !flush && !stall && !m_hseen) begin
            m_v[0]  <= 1'b1;
            m_op[0] <= id_opcode;
            m_rd[0] <= id_rd;
            if (id_opcode == 4'd15) m_hseen <= 1'b1;
         end else begin
            m_v[0] <= 1'b0;
         end
         for (int i = 1; i < 3; i++) begin
            m_v[i]  <= m_v[i-1];
            m_op[i] <= m_op[i-1];
            m_rd[i] <= m_rd[i-1];
         end
      end
   end

   function automatic bit writes_reg(input logic [3:0] op);
      return (op <= 4'd8) || op == 4'd10 || op == 4'd11 || op == 4'd14;
   endfunction

   // Expected outputs, derived from which instruction sits in which stage.
   function automatic logic [24:0] expv(input logic h);
      logic [3:0] e, m, w;
      logic ev, mv, wv;
      e = m_op[0]; m = m_op[1]; w = m_op[2];
      ev = m_v[0]; mv = m_v[1]; wv = m_v[2];
      return {(id_opcode == 4'd10 || id_opcode == 4'd11), (stall | mem_busy | m_hseen),
              ev, ev & (e >= 4'd4 && e <= 4'd11), ev & (e == 4'd12 || e == 4'd13), ev & (e == 4'd14),
              (ev ? e : 4'd0),
              mv, mv & (m == 4'd8 || m == 4'd9), mv & (m == 4'd9), (mv ? m_rd[1] : {RW{1'b0}}),
              wv, wv & (w == 4'd8), wv & writes_reg(w), (wv ? m_rd[2] : {RW{1'b0}}),
              h};
   endfunction

   logic [24:0] a_vec, b_vec;
   assign a_vec = {a_id_reg_src1, a_id_stall_fetch, a_ex_valid, a_ex_alu_src, a_ex_branch, a_ex_pcs,
                   a_ex_alu_op, a_mem_valid, a_mem_enable, a_mem_write, a_mem_rd,
                   a_wb_valid, a_wb_mem_to_reg, a_wb_reg_write, a_wb_rd, a_halted};
   assign b_vec = {b_id_reg_src1, b_id_stall_fetch, b_ex_valid, b_ex_alu_src, b_ex_branch, b_ex_pcs,
                   b_ex_alu_op, b_mem_valid, b_mem_enable, b_mem_write, b_mem_rd,
                   b_wb_valid, b_wb_mem_to_reg, b_wb_reg_write, b_wb_rd, b_halted};

   always @(negedge clk) begin
      if (started) begin
         chk("drain1_outputs", {7'd0, a_vec}, {7'd0, expv(m_halted)});
         chk("drain0_outputs", {7'd0, b_vec}, {7'd0, expv(m_hseen)});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit v, input int op, input int rd, input bit st, input bit fl, input bit mb);
      id_valid  = v;
      id_opcode = op[3:0];
      id_rd     = rd[RW-1:0];
      stall     = st;
      flush     = fl;
      mem_busy  = mb;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0, 0);
      repeat (n) cyc();
   endtask

   initial begin
      cyc();
      cyc();
      started = 1'b1;
      rst_n = 1'b1;
      idle(2);

      // asynchronous reset with a LW in EX
      drive(1, 8, 3, 0, 0, 0);
      cyc();
      chk("lw_in_ex_valid", a_ex_valid, 1);
      chk("lw_in_ex_alu_op", a_ex_alu_op, 8);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_ex_valid", a_ex_valid, 0);
      chk("async_rst_mem_valid", a_mem_valid, 0);
      chk("async_rst_wb_valid", a_wb_valid, 0);
      chk("async_rst_halted", a_halted, 0);
      cyc();
      rst_n = 1'b1;
      idle(2);

      // LW rd=3 then ADD rd=5
      drive(1, 8, 3, 0, 0, 0);
      cyc();
      drive(1, 0, 5, 0, 0, 0);
      cyc();
      chk("lw_mem_enable", a_mem_enable, 1);
      chk("lw_mem_rd", a_mem_rd, 3);
      idle(1);
      chk("lw_wb_mem_to_reg", a_wb_mem_to_reg, 1);
      chk("lw_wb_reg_write", a_wb_reg_write, 1);
      chk("lw_wb_rd", a_wb_rd, 3);
      cyc();
      chk("add_wb_mem_to_reg", a_wb_mem_to_reg, 0);
      chk("add_wb_reg_write", a_wb_reg_write, 1);
      chk("add_wb_rd", a_wb_rd, 5);
      idle(3);

      // SW followed by a one-cycle stall
      drive(1, 9, 2, 0, 0, 0);
      cyc();
      chk("sw_ex_alu_src", a_ex_alu_src, 1);
      drive(1, 0, 4, 1, 0, 0);
      cyc();
      chk("stall_bubble_ex_valid", a_ex_valid, 0);
      chk("sw_mem_enable", a_mem_enable, 1);
      chk("sw_mem_write", a_mem_write, 1);
      idle(1);
      chk("sw_wb_valid", a_wb_valid, 1);
      chk("sw_wb_reg_write", a_wb_reg_write, 0);
      idle(3);

      // branch in EX, flush kills LLB in ID
      drive(1, 12, 0, 0, 0, 0);
      cyc();
      chk("b_ex_branch", a_ex_branch, 1);
      drive(1, 10, 6, 0, 1, 0);
      #1;
      chk("llb_reg_src1", a_id_reg_src1, 1);
      cyc();
      chk("flushed_llb_ex_valid", a_ex_valid, 0);
      chk("flushed_llb_ex_branch", a_ex_branch, 0);
      chk("b_mem_valid", a_mem_valid, 1);
      idle(3);

      // mem_busy for 3 cycles with ADD in MEM
      drive(1, 0, 7, 0, 0, 0);
      cyc();
      idle(1);
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("busy_mem_rd", a_mem_rd, 7);
         chk("busy_wb_valid", a_wb_valid, 0);
      end
      idle(1);
      chk("busy_release_wb_rd", a_wb_rd, 7);
      chk("busy_release_wb_reg_write", a_wb_reg_write, 1);
      chk("busy_release_mem_valid", a_mem_valid, 0);
      idle(3);

      // HLT then ADD
      drive(1, 15, 1, 0, 0, 0);
      cyc();
      chk("hlt_stall_fetch", a_id_stall_fetch, 1);
      chk("hlt_ex_valid", a_ex_valid, 1);
      chk("hlt_halted_early", a_halted, 0);
      chk("hlt_nodrain_halted", b_halted, 1);
      drive(1, 0, 5, 0, 0, 0);
      cyc();
      chk("hlt_add_squashed", a_ex_valid, 0);
      chk("hlt_halted_edge1", a_halted, 0);
      cyc();
      chk("hlt_halted_edge2", a_halted, 1);
      chk("hlt_wb_reg_write", a_wb_reg_write, 0);
      idle(3);
      chk("hlt_halted_sticky", a_halted, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("hlt_rst_halted", a_halted, 0);
      chk("hlt_rst_halted_nodrain", b_halted, 0);
      cyc();
      rst_n = 1'b1;
      idle(2);

      // randomized episodes, each ended by an asynchronous reset
      for (int ep = 0; ep < 15; ep++) begin
         for (int c = 0; c < 200; c++) begin
            drive(($urandom % 10) < 8,
                  (($urandom % 100) == 0) ? 15 : int'($urandom % 15),
                  int'($urandom % 16),
                  ($urandom % 100) < 15,
                  ($urandom % 100) < 10,
                  ($urandom % 100) < 15);
            cyc();
         end
         #1 rst_n = 1'b0;
         cyc();
         rst_n = 1'b1;
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
